// File: rtl/ofdm_rx_rev_seq.sv
// ofdm_rx_rev_seq
// ----------------------------------------------------------------------------
// Receive-side sequencer for the spectrum-reversal stage and the FFT input.
// Counts upstream sample strobes, discards the cyclic prefix and frames the
// remaining FFT_LEN samples of every symbol. It drives the reverser enable, a
// per-symbol sign-phase sync pulse and the FFT frame start/end marks. This is
// a control-only block: no I/Q data passes through it. All strobes are
// registered, so they lag the causing in_valid by exactly one clock.
// Upstream data therefore needs one register of delay to line up with them.
//
// Optional feature: define REV_SEQ_SIGN_OUT_EN to add the rev_sign output.
// rev_sign is 0 (pass) on the first data sample of each symbol and toggles on
// every following data sample, so a sign-select reverser can be driven directly.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   start      one-cycle pulse, begins a burst of nsym symbols (idle only)
//   nsym       symbols in the burst, sampled when start is accepted
//   abort      terminates a running burst on the next edge
//   in_valid   one upstream sample present this cycle
//   rev_en     reverser/FFT accepts the aligned sample (data portion only)
//   rev_sync   reset reverser sign phase, coincident with first data sample
//   fft_sof    first data sample of a symbol
//   fft_eof    last data sample of a symbol
//   sample_idx index of the current data sample, 0..FFT_LEN-1
//   sym_idx    index of the current symbol within the burst
//   busy       burst in progress
//   done       one-cycle pulse at burst completion or abort
//   rev_sign   (REV_SEQ_SIGN_OUT_EN only) reverser sign select, 0 = pass
// ----------------------------------------------------------------------------
module ofdm_rx_rev_seq #(
    parameter int FFT_LEN = 64,
    parameter int CP_LEN  = 16,
    parameter int NSYM_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NSYM_W-1:0]          nsym,
    input  logic                       abort,
    input  logic                       in_valid,
    output logic                       rev_en,
    output logic                       rev_sync,
    output logic                       fft_sof,
    output logic                       fft_eof,
    output logic [$clog2(FFT_LEN)-1:0] sample_idx,
    output logic [NSYM_W-1:0]          sym_idx,
    output logic                       busy,
    output logic                       done
`ifdef REV_SEQ_SIGN_OUT_EN
    ,
    output logic                       rev_sign
`endif
);

    localparam int IDX_W = $clog2(FFT_LEN);
    // CP_LEN < FFT_LEN, so the prefix counter fits in the data-index width.
    localparam logic [IDX_W-1:0] CP_LAST  = IDX_W'((CP_LEN == 0) ? 0 : CP_LEN - 1);
    localparam logic [IDX_W-1:0] FFT_LAST = IDX_W'(FFT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        DATA = 2'd2,
        FIN  = 2'd3
    } state_t;

    // With no cyclic prefix every symbol boundary goes straight back to DATA.
    localparam state_t SYM_ENTRY = (CP_LEN == 0) ? DATA : CP;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cp_cnt_q, cp_cnt_d;
    logic [IDX_W-1:0]   data_cnt_q, data_cnt_d;
    logic [NSYM_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [NSYM_W-1:0]  nsym_q, nsym_d;

    logic               rev_en_q, rev_en_d;
    logic               rev_sync_q, rev_sync_d;
    logic               fft_sof_q, fft_sof_d;
    logic               fft_eof_q, fft_eof_d;
    logic [IDX_W-1:0]   sample_idx_q, sample_idx_d;
    logic [NSYM_W-1:0]  sym_idx_q, sym_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef REV_SEQ_SIGN_OUT_EN
    logic               rev_sign_q, rev_sign_d;
`endif

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cp_cnt_d     = cp_cnt_q;
        data_cnt_d   = data_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        nsym_d       = nsym_q;
        rev_en_d     = 1'b0;
        rev_sync_d   = 1'b0;
        fft_sof_d    = 1'b0;
        fft_eof_d    = 1'b0;
        sample_idx_d = sample_idx_q;
        sym_idx_d    = sym_idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef REV_SEQ_SIGN_OUT_EN
        rev_sign_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (nsym != '0) begin
                        nsym_d     = nsym;
                        sym_cnt_d  = '0;
                        sym_idx_d  = '0;
                        cp_cnt_d   = '0;
                        data_cnt_d = '0;
                        busy_d     = 1'b1;
                        state_d    = SYM_ENTRY;
                    end else begin
                        // Empty burst: report completion without going busy.
                        done_d = 1'b1;
                    end
                end
            end

            CP: begin
                if (in_valid) begin
                    if (cp_cnt_q == CP_LAST) begin
                        cp_cnt_d = '0;
                        state_d  = DATA;
                    end else begin
                        cp_cnt_d = cp_cnt_q + IDX_W'(1);
                    end
                end
            end

            DATA: begin
                if (in_valid) begin
                    rev_en_d     = 1'b1;
                    sample_idx_d = data_cnt_q;
                    sym_idx_d    = sym_cnt_q;
                    rev_sync_d   = (data_cnt_q == '0);
                    fft_sof_d    = (data_cnt_q == '0);
`ifdef REV_SEQ_SIGN_OUT_EN
                    // Sign phase restarts at 0 on every symbol, so it is the
                    // LSB of the data index.
                    rev_sign_d   = data_cnt_q[0];
`endif
                    if (data_cnt_q == FFT_LAST) begin
                        fft_eof_d  = 1'b1;
                        data_cnt_d = '0;
                        if (sym_cnt_q == nsym_q - NSYM_W'(1)) begin
                            state_d = FIN;
                        end else begin
                            sym_cnt_d = sym_cnt_q + NSYM_W'(1);
                            state_d   = SYM_ENTRY;
                        end
                    end else begin
                        data_cnt_d = data_cnt_q + IDX_W'(1);
                    end
                end
            end

            FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Abort overrides everything above once a burst has been accepted.
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            cp_cnt_d     = '0;
            data_cnt_d   = '0;
            sym_cnt_d    = '0;
            rev_en_d     = 1'b0;
            rev_sync_d   = 1'b0;
            fft_sof_d    = 1'b0;
            fft_eof_d    = 1'b0;
            sample_idx_d = '0;
            sym_idx_d    = '0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
`ifdef REV_SEQ_SIGN_OUT_EN
            rev_sign_d   = 1'b0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cp_cnt_q     <= '0;
            data_cnt_q   <= '0;
            sym_cnt_q    <= '0;
            nsym_q       <= '0;
            rev_en_q     <= 1'b0;
            rev_sync_q   <= 1'b0;
            fft_sof_q    <= 1'b0;
            fft_eof_q    <= 1'b0;
            sample_idx_q <= '0;
            sym_idx_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef REV_SEQ_SIGN_OUT_EN
            rev_sign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cp_cnt_q     <= cp_cnt_d;
            data_cnt_q   <= data_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            nsym_q       <= nsym_d;
            rev_en_q     <= rev_en_d;
            rev_sync_q   <= rev_sync_d;
            fft_sof_q    <= fft_sof_d;
            fft_eof_q    <= fft_eof_d;
            sample_idx_q <= sample_idx_d;
            sym_idx_q    <= sym_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef REV_SEQ_SIGN_OUT_EN
            rev_sign_q   <= rev_sign_d;
`endif
        end
    end

    assign rev_en     = rev_en_q;
    assign rev_sync   = rev_sync_q;
    assign fft_sof    = fft_sof_q;
    assign fft_eof    = fft_eof_q;
    assign sample_idx = sample_idx_q;
    assign sym_idx    = sym_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef REV_SEQ_SIGN_OUT_EN
    assign rev_sign   = rev_sign_q;
`endif

endmodule

// File: tb/tb_ofdm_rx_rev_seq.sv
// tb_ofdm_rx_rev_seq
// ----------------------------------------------------------------------------
// Self-checking bench for ofdm_rx_rev_seq. Two instances share one stimulus
// stream: instance A uses the default geometry (FFT_LEN=64, CP_LEN=16) and
// instance B a short symbol with no prefix (FFT_LEN=8, CP_LEN=0). Each cycle
// the bench predicts every output of both instances for the next edge from a
// sample-position model and pushes the prediction to a per-instance queue.
// The prediction is popped and compared on the following falling edge.
// Define REV_SEQ_SIGN_OUT_EN to also cover rev_sign.
// ----------------------------------------------------------------------------
module tb_ofdm_rx_rev_seq;

    typedef struct {
        logic en;
        logic sync;
        logic sof;
        logic eof;
        logic sign;
        logic busy;
        logic done;
        int   sidx;
        int   symi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] nsym = '0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;

    logic       a_en, a_sync, a_sof, a_eof, a_busy, a_done, a_sign;
    logic [5:0] a_sidx;
    logic [7:0] a_symi;
    logic       b_en, b_sync, b_sof, b_eof, b_busy, b_done, b_sign;
    logic [2:0] b_sidx;
    logic [7:0] b_symi;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ofdm_rx_rev_seq #(.FFT_LEN(64), .CP_LEN(16), .NSYM_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .nsym(nsym), .abort(abort),
        .in_valid(in_valid), .rev_en(a_en), .rev_sync(a_sync),
        .fft_sof(a_sof), .fft_eof(a_eof), .sample_idx(a_sidx),
        .sym_idx(a_symi), .busy(a_busy), .done(a_done)
`ifdef REV_SEQ_SIGN_OUT_EN
        , .rev_sign(a_sign)
`endif
    );

    ofdm_rx_rev_seq #(.FFT_LEN(8), .CP_LEN(0), .NSYM_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .nsym(nsym), .abort(abort),
        .in_valid(in_valid), .rev_en(b_en), .rev_sync(b_sync),
        .fft_sof(b_sof), .fft_eof(b_eof), .sample_idx(b_sidx),
        .sym_idx(b_symi), .busy(b_busy), .done(b_done)
`ifdef REV_SEQ_SIGN_OUT_EN
        , .rev_sign(b_sign)
`endif
    );

`ifndef REV_SEQ_SIGN_OUT_EN
    assign a_sign = 1'b0;
    assign b_sign = 1'b0;
`endif

    // Model state, one slot per instance.
    int   m_fft [2] = '{64, 8};
    int   m_cp  [2] = '{16, 0};
    bit   m_act [2];
    bit   m_fin [2];
    int   m_pos [2];
    int   m_nsym[2];
    exp_t m_last[2];
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.en = 0; e.sync = 0; e.sof = 0; e.eof = 0; e.sign = 0;
        e.busy = 0; e.done = 0; e.sidx = 0; e.symi = 0;
        return e;
    endfunction

    function automatic exp_t observe(input int i);
        exp_t o;
        if (i == 0) begin
            o.en = a_en; o.sync = a_sync; o.sof = a_sof; o.eof = a_eof;
            o.sign = a_sign; o.busy = a_busy; o.done = a_done;
            o.sidx = int'(a_sidx); o.symi = int'(a_symi);
        end else begin
            o.en = b_en; o.sync = b_sync; o.sof = b_sof; o.eof = b_eof;
            o.sign = b_sign; o.busy = b_busy; o.done = b_done;
            o.sidx = int'(b_sidx); o.symi = int'(b_symi);
        end
        return o;
    endfunction

    task automatic compare(input string nm, input exp_t o, input exp_t e);
        check({nm, ".rev_en"},     int'(o.en),   int'(e.en));
        check({nm, ".rev_sync"},   int'(o.sync), int'(e.sync));
        check({nm, ".fft_sof"},    int'(o.sof),  int'(e.sof));
        check({nm, ".fft_eof"},    int'(o.eof),  int'(e.eof));
        check({nm, ".busy"},       int'(o.busy), int'(e.busy));
        check({nm, ".done"},       int'(o.done), int'(e.done));
        check({nm, ".sample_idx"}, o.sidx,       e.sidx);
        check({nm, ".sym_idx"},    o.symi,       e.symi);
`ifdef REV_SEQ_SIGN_OUT_EN
        check({nm, ".rev_sign"},   int'(o.sign), int'(e.sign));
`endif
    endtask

    task automatic cmp_all();
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            compare("A", observe(0), e);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            compare("B", observe(1), e);
        end
    endtask

    // Predict instance i's outputs after the coming edge from its position
    // in the burst: pos counts accepted samples, CP first, then data.
    task automatic model_step(input int i, input bit st, input int ns,
                              input bit ab, input bit v);
        exp_t e;
        int   period, sym, off;
        e = m_last[i];
        e.en = 0; e.sync = 0; e.sof = 0; e.eof = 0; e.sign = 0; e.done = 0;
        period = m_fft[i] + m_cp[i];
        if (m_act[i] && ab) begin
            m_act[i] = 0; m_fin[i] = 0;
            e.busy = 0; e.done = 1; e.sidx = 0; e.symi = 0;
        end else if (m_fin[i]) begin
            m_fin[i] = 0; m_act[i] = 0;
            e.busy = 0; e.done = 1;
        end else if (!m_act[i]) begin
            if (st) begin
                if (ns != 0) begin
                    m_act[i] = 1; m_pos[i] = 0; m_nsym[i] = ns;
                    e.busy = 1; e.symi = 0;
                end else begin
                    e.done = 1;
                end
            end
        end else if (v) begin
            sym = m_pos[i] / period;
            off = m_pos[i] % period;
            if (off >= m_cp[i]) begin
                e.en   = 1;
                e.sidx = off - m_cp[i];
                e.symi = sym;
                e.sync = (off == m_cp[i]);
                e.sof  = (off == m_cp[i]);
                e.eof  = (off == period - 1);
                e.sign = ((off - m_cp[i]) % 2) == 1;
                if (e.eof && sym == m_nsym[i] - 1) m_fin[i] = 1;
            end
            m_pos[i]++;
        end
        m_last[i] = e;
        if (i == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic cycle(input bit st, input int ns, input bit ab, input bit v);
        @(negedge clk);
        cmp_all();
        start    = st;
        nsym     = 8'(ns);
        abort    = ab;
        in_valid = v;
        model_step(0, st, ns, ab, v);
        model_step(1, st, ns, ab, v);
    endtask

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_fin[i] = 0; m_pos[i] = 0; m_nsym[i] = 0;
            m_last[i] = zero_exp();
        end
    endtask

    initial begin
        model_reset();

        // Reset state while rst is held.
        #3;
        compare("A.rst", observe(0), zero_exp());
        compare("B.rst", observe(1), zero_exp());
        @(negedge clk);
        rst = 1'b0;

        // Two-symbol burst, continuous samples; a start mid-burst is ignored.
        cycle(1, 2, 0, 0);
        for (int k = 0; k < 170; k++) begin
            if (k == 10) cycle(1, 5, 0, 1);
            else         cycle(0, 0, 0, 1);
        end
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0);

        // One symbol with a 1-of-3 sample duty.
        cycle(1, 1, 0, 0);
        for (int k = 0; k < 80 * 3 + 6; k++) cycle(0, 0, 0, (k % 3) == 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0);

        // Abort at data sample 30 of symbol 0, then a clean one-symbol burst.
        cycle(1, 1, 0, 0);
        for (int k = 0; k < 16 + 30; k++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);               // abort while idle is ignored
        cycle(1, 1, 0, 0);
        for (int k = 0; k < 84; k++) cycle(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);

        // Empty burst.
        cycle(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);

        // Three short symbols back to back on B; A is aborted afterwards.
        cycle(1, 3, 0, 0);
        for (int k = 0; k < 30; k++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);

        // Random traffic with occasional starts and aborts.
        for (int k = 0; k < 1500; k++) begin
            cycle($urandom_range(0, 19) == 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
        end
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);

        // Asynchronous reset in the middle of DATA.
        cycle(1, 1, 0, 0);
        for (int k = 0; k < 40; k++) cycle(0, 0, 0, 1);
        @(posedge clk);
        #1;
        cmp_all();
        #2;
        rst = 1'b1;
        #1;
        compare("A.arst", observe(0), zero_exp());
        compare("B.arst", observe(1), zero_exp());
        model_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        cmp_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
